// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 256-bit off-chip memory port between the I-cache
// refill port (p0) and the D-cache port (p1). A registered grant FSM picks a
// port (fixed priority to p1, or round-robin). It steers that port's request
// to the mem_* pins and routes the memory ack back to it. A watchdog flags a
// memory that never acknowledges a granted request.
module mem_arbiter #(
  parameter int RR   = 1,  // 1: round-robin on ties, 0: p1 always wins ties
  parameter int TO_W = 8   // watchdog width; fires at 2^TO_W-1 silent cycles
) (
  input  logic         clk_i,
  input  logic         rst_i,

  input  logic         p0_enable_i,
  input  logic         p0_write_i,
  input  logic [31:0]  p0_addr_i,
  input  logic [255:0] p0_data_i,
  output logic [255:0] p0_data_o,
  output logic         p0_ack_o,

  input  logic         p1_enable_i,
  input  logic         p1_write_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [255:0] p1_data_i,
  output logic [255:0] p1_data_o,
  output logic         p1_ack_o,

  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [255:0] mem_data_o,
  output logic [31:0]  mem_addr_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,

  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // Watchdog saturation value and the value one below it. The error flag is
  // raised on the edge where the counter steps from WD_LAST to WD_MAX.
  localparam logic [TO_W-1:0] WD_MAX  = {TO_W{1'b1}};
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] WD_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state_reg;
  logic            last_reg;      // last port served: 0 = p0, 1 = p1
  logic [TO_W-1:0] wd_reg;
  logic            err_reg;

  // Enable of whichever port currently holds the grant. It detects aborts.
  logic            granted_enable;

  // Grant FSM: arbitration in IDLE, completion/abort in GRANTx, watchdog.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;          // p1 counts as last served, so p0 wins the first tie
      wd_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A memory ack arriving here is stray and is simply ignored.
          if (p0_enable_i && p1_enable_i) begin
            if ((RR != 0) && last_reg) begin
              state_reg <= GRANT0;
            end else begin
              state_reg <= GRANT1;
            end
            wd_reg <= '0;
          end else if (p0_enable_i) begin
            state_reg <= GRANT0;
            wd_reg    <= '0;
          end else if (p1_enable_i) begin
            state_reg <= GRANT1;
            wd_reg    <= '0;
          end
        end

        GRANT0, GRANT1: begin
          if (mem_ack_i) begin
            // Completion: always pass through IDLE before the next grant.
            state_reg <= IDLE;
            last_reg  <= (state_reg == GRANT1);
          end else begin
            // Silent granted cycle: count it and saturate. The grant is
            // held on timeout; only the error flag reports it.
            if (wd_reg != WD_MAX) begin
              wd_reg <= wd_reg + WD_ONE;
            end
            if (wd_reg == WD_LAST) begin
              err_reg <= 1'b1;
            end
            // Requester withdrew before any ack: abort without touching
            // the fairness pointer.
            if (!granted_enable) begin
              state_reg <= IDLE;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // Request steering and ack routing for the port that holds the grant.
  always_comb begin
    mem_enable_o   = 1'b0;
    mem_write_o    = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    p0_ack_o       = 1'b0;
    p1_ack_o       = 1'b0;
    granted_enable = 1'b0;
    case (state_reg)
      GRANT0: begin
        mem_enable_o   = p0_enable_i;
        mem_write_o    = p0_write_i;
        mem_addr_o     = p0_addr_i;
        mem_data_o     = p0_data_i;
        p0_ack_o       = mem_ack_i;
        granted_enable = p0_enable_i;
      end
      GRANT1: begin
        mem_enable_o   = p1_enable_i;
        mem_write_o    = p1_write_i;
        mem_addr_o     = p1_addr_i;
        mem_data_o     = p1_data_i;
        p1_ack_o       = mem_ack_i;
        granted_enable = p1_enable_i;
      end
      default: begin
        granted_enable = 1'b0;
      end
    endcase
  end

  // Read data is broadcast to both ports; each port qualifies it with its ack.
  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;

  assign busy_o = (state_reg != IDLE);
  assign err_o  = err_reg;

endmodule
